// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and default sizes for the I2S transmit frame controller
// Provides the default sample/slot widths, the controller state enum and the
// stereo sample pair type used at the source interfaces.
package i2s_pkg;

    localparam int SAMPLE_W_DEF = 24;
    localparam int SLOT_W_DEF   = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } tx_state_t;

    typedef struct packed {
        logic signed [SAMPLE_W_DEF-1:0] left;
        logic signed [SAMPLE_W_DEF-1:0] right;
    } stereo_pair_t;

endpackage

// File: rtl/i2s_slot_serializer.sv
// rtl/i2s_slot_serializer.sv - combinational frame-position to WS/serial-bit mapping
// Ports:
//   bit_counter  in   position in the frame, 0..2*SLOT_W-1
//   left, right  in   active sample pair
//   sound_bit    out  serial data bit for this position, MSB first
//   word_select  out  I2S WS, leading the data by one bit
module i2s_slot_serializer #(
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32,
    parameter int CNT_W    = 6
) (
    input  logic [CNT_W-1:0]    bit_counter,
    input  logic [SAMPLE_W-1:0] left,
    input  logic [SAMPLE_W-1:0] right,
    output logic                sound_bit,
    output logic                word_select
);

    localparam int FRAME = 2 * SLOT_W;

    int                  c;
    int                  p;
    int                  k;
    logic [SAMPLE_W-1:0] word;
    logic [SAMPLE_W-1:0] mask;

    always_comb begin
        c = int'(bit_counter);
        // Data runs one bit behind WS, so position c carries bit p = c-1
        // (mod frame); c=0 therefore still shows the previous right LSB slot.
        p = (c == 0) ? FRAME - 1 : c - 1;
        word = (p >= SLOT_W) ? right : left;
        k = (p >= SLOT_W) ? p - SLOT_W : p;
        mask = '0;
        if (k < SAMPLE_W) begin
            mask = SAMPLE_W'(1) << (SAMPLE_W - 1 - k);
        end
        sound_bit   = |(word & mask);
        word_select = (c >= SLOT_W - 1) && (c <= FRAME - 2);
    end

endmodule

// File: rtl/i2s_tx_frame_controller.sv
// rtl/i2s_tx_frame_controller.sv - I2S transmit frame sequencer with dual-source sample fetch
// Ports:
//   serial_clk, reset         bit clock; asynchronous active-high reset
//   enable                    run request; a stop always completes the current frame
//   src_sel                   source choice, latched at each frame start
//   srcN_valid/ready/left/right  per-source sample pair handshake
//   word_select, sound_bit_out   I2S WS and serial data
//   bit_counter, frame_start  frame position and frame-start pulse
//   underflow, underflow_count   failed-fetch pulse and saturating count
//   busy                      frame sequencing active
module i2s_tx_frame_controller
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int SLOT_W   = SLOT_W_DEF,
    parameter int CNT_W    = $clog2(2 * SLOT_W)
) (
    input  logic                       serial_clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       src_sel,
    input  logic                       src0_valid,
    output logic                       src0_ready,
    input  logic signed [SAMPLE_W-1:0] src0_left,
    input  logic signed [SAMPLE_W-1:0] src0_right,
    input  logic                       src1_valid,
    output logic                       src1_ready,
    input  logic signed [SAMPLE_W-1:0] src1_left,
    input  logic signed [SAMPLE_W-1:0] src1_right,
    output logic                       word_select,
    output logic                       sound_bit_out,
    output logic [CNT_W-1:0]           bit_counter,
    output logic                       frame_start,
    output logic                       underflow,
    output logic [7:0]                 underflow_count,
    output logic                       busy
);

    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(2 * SLOT_W - 1);
    localparam logic [CNT_W-1:0] FETCH_C = CNT_W'(2 * SLOT_W - 2);

    tx_state_t           state;
    tx_state_t           state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [CNT_W-1:0]    cnt_inc;
    logic                sel_q;
    logic [SAMPLE_W-1:0] pend_left;
    logic [SAMPLE_W-1:0] pend_right;
    logic [SAMPLE_W-1:0] act_left;
    logic [SAMPLE_W-1:0] act_right;
    logic                fetch;
    logic                fetch_valid;
    logic                ser_bit;
    logic                ser_ws;

    assign cnt_inc = (cnt == LAST_C) ? '0 : cnt + 1'b1;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                cnt_next = cnt_inc;
                if (!enable) begin
                    if (cnt == '0) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt == LAST_C) begin
                        // Stop seen on the last bit: the frame is already complete.
                        state_next = IDLE;
                    end else begin
                        state_next = STOPPING;
                    end
                end
            end
            STOPPING: begin
                cnt_next = cnt_inc;
                if (enable) begin
                    state_next = RUN;
                end else if (cnt == LAST_C) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign fetch       = (state == RUN) && (cnt == FETCH_C);
    assign fetch_valid = sel_q ? src1_valid : src0_valid;
    assign src0_ready  = fetch & ~sel_q;
    assign src1_ready  = fetch & sel_q;
    assign underflow   = fetch & ~fetch_valid;

    always_ff @(posedge serial_clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            sel_q           <= 1'b0;
            pend_left       <= '0;
            pend_right      <= '0;
            act_left        <= '0;
            act_right       <= '0;
            underflow_count <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state_next == RUN && cnt_next == '0) begin
                sel_q <= src_sel;
            end
            if (state == IDLE) begin
                // Clearing here makes the first frame after a restart play zeros
                // instead of a pair left over from before the stop.
                pend_left  <= '0;
                pend_right <= '0;
                act_left   <= '0;
                act_right  <= '0;
            end else begin
                if (fetch) begin
                    if (fetch_valid) begin
                        pend_left  <= sel_q ? src1_left  : src0_left;
                        pend_right <= sel_q ? src1_right : src0_right;
                    end else begin
                        pend_left  <= '0;
                        pend_right <= '0;
                    end
                end
                // Swap on leaving c=0 so the previous right LSB slot stays intact.
                if (state == RUN && cnt == '0) begin
                    act_left  <= pend_left;
                    act_right <= pend_right;
                end
            end
            if (underflow && underflow_count != 8'hFF) begin
                underflow_count <= underflow_count + 8'd1;
            end
        end
    end

    i2s_slot_serializer #(
        .SAMPLE_W (SAMPLE_W),
        .SLOT_W   (SLOT_W),
        .CNT_W    (CNT_W)
    ) u_serializer (
        .bit_counter (cnt),
        .left        (act_left),
        .right       (act_right),
        .sound_bit   (ser_bit),
        .word_select (ser_ws)
    );

    assign busy          = (state != IDLE);
    assign bit_counter   = cnt;
    assign frame_start   = (state == RUN) && (cnt == '0);
    assign sound_bit_out = busy & ser_bit;
    assign word_select   = busy & ser_ws;

endmodule

// File: tb/tb_i2s_tx_frame_controller.sv
// tb/tb_i2s_tx_frame_controller.sv - directed self-checking bench for i2s_tx_frame_controller
module tb_i2s_tx_frame_controller;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        src_sel;
    logic        src0_valid;
    logic        src0_ready;
    logic [23:0] src0_left;
    logic [23:0] src0_right;
    logic        src1_valid;
    logic        src1_ready;
    logic [23:0] src1_left;
    logic [23:0] src1_right;
    logic        word_select;
    logic        sound_bit_out;
    logic [5:0]  bit_counter;
    logic        frame_start;
    logic        underflow;
    logic [7:0]  underflow_count;
    logic        busy;

    i2s_tx_frame_controller dut (
        .serial_clk      (clk),
        .reset           (reset),
        .enable          (enable),
        .src_sel         (src_sel),
        .src0_valid      (src0_valid),
        .src0_ready      (src0_ready),
        .src0_left       (src0_left),
        .src0_right      (src0_right),
        .src1_valid      (src1_valid),
        .src1_ready      (src1_ready),
        .src1_left       (src1_left),
        .src1_right      (src1_right),
        .word_select     (word_select),
        .sound_bit_out   (sound_bit_out),
        .bit_counter     (bit_counter),
        .frame_start     (frame_start),
        .underflow       (underflow),
        .underflow_count (underflow_count),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame captures: bit (63-c) holds the value seen at bit_counter=c.
    localparam logic [63:0] SD_A5   = {1'b0, 24'hA5A5A5, 8'h00, 24'h5A5A5A, 7'h00};
    localparam logic [63:0] SD_S1   = {1'b0, 24'h123456, 8'h00, 24'hFEDCBA, 7'h00};
    localparam logic [63:0] WS_PAT  = {31'h0, 32'hFFFF_FFFF, 1'b0};
    localparam logic [63:0] FS_PAT  = {1'b1, 63'h0};
    localparam logic [63:0] RDY_PAT = 64'h2;
    localparam logic [63:0] ALL1    = {64{1'b1}};

    int n_cmp = 0;
    int n_bad = 0;

    logic [12:0] pins;
    assign pins = {word_select, sound_bit_out, bit_counter, frame_start,
                   underflow, busy, src0_ready, src1_ready};

    int          en_off_c = -1;
    int          en_on_c  = -1;
    int          sel_c    = -1;
    int          bc_err;
    logic [63:0] cap_sd, cap_ws, cap_fs, cap_r0, cap_r1, cap_uf, cap_busy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with bit_counter expected at 0; returns at the next frame's c=0.
    task automatic run_frame();
        cap_sd = '0; cap_ws = '0; cap_fs = '0; cap_r0 = '0;
        cap_r1 = '0; cap_uf = '0; cap_busy = '0; bc_err = 0;
        for (int c = 0; c < 64; c++) begin
            if (int'(bit_counter) != c) bc_err++;
            cap_sd   = {cap_sd[62:0], sound_bit_out};
            cap_ws   = {cap_ws[62:0], word_select};
            cap_fs   = {cap_fs[62:0], frame_start};
            cap_r0   = {cap_r0[62:0], src0_ready};
            cap_r1   = {cap_r1[62:0], src1_ready};
            cap_uf   = {cap_uf[62:0], underflow};
            cap_busy = {cap_busy[62:0], busy};
            if (c == en_off_c) enable = 1'b0;
            if (c == en_on_c)  enable = 1'b1;
            if (c == sel_c)    src_sel = ~src_sel;
            @(negedge clk);
        end
        en_off_c = -1;
        en_on_c  = -1;
        sel_c    = -1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; src_sel = 1'b0;
        src0_valid = 1'b1; src0_left = 24'hA5A5A5; src0_right = 24'h5A5A5A;
        src1_valid = 1'b1; src1_left = 24'h123456; src1_right = 24'hFEDCBA;
        repeat (3) @(negedge clk);
        chk("reset_pins", 64'(pins), 64'd0);
        chk("reset_ucnt", 64'(underflow_count), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_pins", 64'(pins), 64'd0);

        // Basic playback: frame 1 silent, frame 2 carries the src0 pair.
        enable = 1'b1;
        @(negedge clk);
        run_frame();
        chk("f1_sd", cap_sd, 64'd0);
        chk("f1_ws", cap_ws, WS_PAT);
        chk("f1_fs", cap_fs, FS_PAT);
        chk("f1_bc", 64'(bc_err), 64'd0);
        chk("f1_r0", cap_r0, RDY_PAT);
        chk("f1_r1", cap_r1, 64'd0);
        chk("f1_uf", cap_uf, 64'd0);
        run_frame();
        chk("f2_sd", cap_sd, SD_A5);
        chk("f2_ws", cap_ws, WS_PAT);
        chk("f2_fs", cap_fs, FS_PAT);
        chk("f2_busy", cap_busy, ALL1);

        // Underflow on the src0 fetch mutes the following frame.
        src0_valid = 1'b0;
        run_frame();
        src0_valid = 1'b1;
        chk("f3_sd", cap_sd, SD_A5);
        chk("f3_uf", cap_uf, RDY_PAT);
        chk("f3_r0", cap_r0, RDY_PAT);
        chk("f3_ucnt", 64'(underflow_count), 64'd1);
        run_frame();
        chk("f4_sd", cap_sd, 64'd0);
        chk("f4_uf", cap_uf, 64'd0);

        // Mid-frame source switch takes effect one frame later.
        sel_c = 10;
        run_frame();
        chk("f5_r0", cap_r0, RDY_PAT);
        chk("f5_r1", cap_r1, 64'd0);
        chk("f5_sd", cap_sd, SD_A5);
        run_frame();
        chk("f6_r0", cap_r0, 64'd0);
        chk("f6_r1", cap_r1, RDY_PAT);
        chk("f6_sd", cap_sd, SD_A5);
        run_frame();
        chk("f7_sd", cap_sd, SD_S1);
        chk("f7_r1", cap_r1, RDY_PAT);

        // Stop mid-frame: frame completes, no fetch, then idle.
        en_off_c = 20;
        run_frame();
        chk("f8_sd", cap_sd, SD_S1);
        chk("f8_rdy", cap_r0 | cap_r1, 64'd0);
        chk("f8_busy", cap_busy, ALL1);
        chk("stop_pins", 64'(pins), 64'd0);
        repeat (5) @(negedge clk);
        chk("idle2_pins", 64'(pins), 64'd0);

        // Restart: first frame silent; then stop/restart inside a frame loses nothing.
        enable = 1'b1;
        @(negedge clk);
        run_frame();
        chk("f9_sd", cap_sd, 64'd0);
        chk("f9_fs", cap_fs, FS_PAT);
        chk("f9_r1", cap_r1, RDY_PAT);
        en_off_c = 20;
        en_on_c  = 40;
        run_frame();
        chk("f10_sd", cap_sd, SD_S1);
        chk("f10_busy", cap_busy, ALL1);
        chk("f10_r1", cap_r1, RDY_PAT);
        run_frame();
        chk("f11_fs", cap_fs, FS_PAT);
        chk("f11_sd", cap_sd, SD_S1);
        chk("f11_ucnt", 64'(underflow_count), 64'd1);

        // Saturation of the underflow counter over 260 failed fetches.
        src1_valid = 1'b0;
        repeat (253) run_frame();
        chk("ucnt_254", 64'(underflow_count), 64'd254);
        run_frame();
        chk("ucnt_255", 64'(underflow_count), 64'd255);
        repeat (6) run_frame();
        chk("ucnt_sat", 64'(underflow_count), 64'd255);
        chk("mute_sd", cap_sd, 64'd0);

        // Asynchronous reset mid-frame, then a clean restart.
        src1_valid = 1'b1;
        repeat (45) @(negedge clk);
        chk("pre_rst_bc", 64'(bit_counter), 64'd45);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pins", 64'(pins), 64'd0);
        chk("async_rst_ucnt", 64'(underflow_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_frame();
        chk("f12_sd", cap_sd, 64'd0);
        chk("f12_bc", 64'(bc_err), 64'd0);
        chk("f12_fs", cap_fs, FS_PAT);
        chk("f12_r1", cap_r1, RDY_PAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_tx_frame_controller.md
Name: i2s_tx_frame_controller

Overview:
- Sequences the I2S transmit path: generates the frame timing (bit_counter, word_select, sound_bit_out) for one stereo serial output.
- Fetches one left/right sample pair per frame from one of two upstream sources (test-tone generator, processed-audio path) via valid/ready.
- Source choice is made at frame boundaries; a missing sample mutes the frame and is counted.
- Sits between the audio sources and the I2S pins, in the serial_clk domain.

Parameters:
- SAMPLE_W, 24, sample width in bits; SAMPLE_W <= SLOT_W.
- SLOT_W, 32, bit slots per channel; frame length is 2*SLOT_W cycles.
- CNT_W, $clog2(2*SLOT_W), bit_counter width; 6 at default.

Ports:
- serial_clk  in  1  serial bit clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request.
- src_sel  in  1  source select: 0 = src0, 1 = src1. Sampled only at frame start.
- src0_valid  in  1  source 0 has a pair available.
- src0_ready  out  1  source 0 pair accepted this cycle.
- src0_left / src0_right  in  SAMPLE_W each  source 0 samples, signed two's complement.
- src1_valid, src1_ready, src1_left, src1_right  as for src0.
- word_select  out  1  I2S WS: 0 = left, 1 = right.
- sound_bit_out  out  1  serial data, MSB first.
- bit_counter  out  CNT_W  position in frame, 0..2*SLOT_W-1.
- frame_start  out  1  one-cycle pulse when bit_counter==0 while running.
- underflow  out  1  one-cycle pulse on a failed fetch.
- underflow_count  out  8  saturating failed-fetch count.
- busy  out  1  frame sequencing active.

Behaviour:
- Reset (asynchronous):
  - Every output is 0, and both ready outputs are 0.
  - The active pair, pending pair and latched select (sel_q) clear to 0.
  - The FSM enters IDLE.
- Reset deassertion mid-frame restarts cleanly from IDLE; no partial frame is resumed.
- FSM states are IDLE, RUN and STOPPING.
  - IDLE to RUN: enable=1. The first RUN cycle has bit_counter=0.
  - RUN to STOPPING: enable=0 seen while bit_counter != 0.
  - RUN to IDLE: enable=0 seen while bit_counter == 0.
  - STOPPING to IDLE: when bit_counter wraps to 0. The current frame always completes.
  - STOPPING to RUN: enable returns to 1 before the wrap; no frame is lost.
  - In IDLE, bit_counter=0, word_select=0, sound_bit_out=0, busy=0. busy=1 in RUN and STOPPING.
- Counter: increments by 1 per cycle in RUN/STOPPING and wraps from 2*SLOT_W-1 to 0.
- word_select = 1 when bit_counter is in [SLOT_W-1, 2*SLOT_W-2], else 0. WS therefore leads the data by one bit (I2S one-bit delay).
- Data mapping at bit_counter=c:
  - p = (c + 2*SLOT_W - 1) mod 2*SLOT_W; ch = right if p >= SLOT_W, else left; k = p mod SLOT_W.
  - sound_bit_out = active_ch[SAMPLE_W-1-k] if k < SAMPLE_W, else 0.
  - Result: left MSB at c=1; right MSB at c=SLOT_W+1; the right LSB of the previous pair can land at c=0.
- Fetch:
  - At c = 2*SLOT_W-2 in RUN, assert ready for exactly one cycle on the source selected by sel_q only. The other ready stays 0.
  - If that source's valid=1 in the same cycle: capture left/right into pending (handshake = valid & ready).
  - Otherwise: pending = 0 (mute), underflow pulses that cycle, underflow_count += 1, saturating at 255 (never wraps).
  - No fetch is made in STOPPING or IDLE.
- Active update: pending is copied to active on the edge leaving c=0, so active is held through c=0 and the previous right LSB is intact.
- The first frame after IDLE plays zeros. Its own fetch feeds frame 2.
- Select timing:
  - sel_q <= src_sel on the edge entering c=0 in RUN.
  - A mid-frame change of src_sel has no effect until the next frame.
  - The fetch at the end of frame N uses the sel_q of frame N.
- valid is not required to stay high. Data is sampled only in the single ready cycle.
- underflow_count clears only on reset.

Decomposition:
- Package i2s_pkg:
  - constants SAMPLE_W_DEF=24, SLOT_W_DEF=32;
  - enum tx_state_t {IDLE, RUN, STOPPING};
  - typedef struct stereo_pair_t {left, right}, SAMPLE_W signed each.
- One sub-module, i2s_slot_serializer: combinational mapping of (bit_counter, active pair) to sound_bit_out and word_select. The controller keeps the FSM, counter, fetch, select and underflow logic.

Test Plan:
1. Reset, then enable=1 with src0_valid=1, src0_left=24'hA5A5A5, src0_right=24'h5A5A5A. Required: frame 1 is all zeros. Frame 2 has ws 0 to 1 at c=31 and 1 to 0 at c=63; c=1..24 shows bits A5A5A5 MSB first; c=25..32 are 0; c=33..56 show 5A5A5A; frame_start pulses at each c=0.
2. src0_valid=0 at the c=62 fetch. Required: underflow pulses exactly at c=62, underflow_count goes 0 to 1, and the next frame outputs all zeros.
3. Toggle src_sel 0 to 1 at c=10. Required: src0_ready still pulses at c=62 of that frame. src1_ready pulses at c=62 of the following frame, and src1 data plays one frame after that.
4. Deassert enable at c=20. Required: the frame completes; busy drops when the counter wraps to 0; no ready pulse at c=62 of that frame; outputs are 0 in IDLE. Re-assert at c=40 instead: frames continue without a gap.
5. Force 260 consecutive underflows. Required: underflow_count saturates at 255.
6. Assert reset at c=45 mid-frame. Required: all outputs go to 0 asynchronously; after release with enable=1, bit_counter restarts at 0 and the first frame is zeros.
